// File: rtl/alu_seq_engine.sv
// Word-serial sequential ALU: ADD/SUB, radix-4 Booth MUL, non-restoring DIV.
// Operands and results move one WIDTH-bit word per cycle over INBUS/OUTBUS.
module alu_seq_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] INBUS,
    output logic [WIDTH-1:0] OUTBUS,
    output logic             finish,
    output logic             busy,
    output logic             err
);

    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ_OP,
        S_READ_1,
        S_READ_2,
        S_READ_3,
        S_OP_1,
        S_OP_2,
        S_DIV_CORR,
        S_OUT_1,
        S_OUT_2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] outbus_q, outbus_d;
    logic             finish_q, finish_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] addend_b;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [AW-1:0]    m_sx;
    logic [AW-1:0]    m_zx;
    logic [AW-1:0]    booth_add;
    logic [AW-1:0]    a_shl;
    logic             div_err;

    always_comb begin
        addend_b = op_q[0] ? ~m_q : m_q;
        sum      = {1'b0, a_q[WIDTH-1:0]} + {1'b0, addend_b}
                 + {{WIDTH{1'b0}}, op_q[0]};
        ovf      = (a_q[WIDTH-1] == addend_b[WIDTH-1])
                 && (sum[WIDTH-1] != a_q[WIDTH-1]);
        m_sx     = {{2{m_q[WIDTH-1]}}, m_q};
        m_zx     = {2'b00, m_q};
        a_shl    = {a_q[WIDTH:0], q_q[WIDTH-1]};
        div_err  = (m_q == '0) || (a_q[WIDTH-1:0] >= m_q);
        // Booth digit from {Q1,Q0,Q-1}: 0, +-M or +-2M
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: booth_add = m_sx;
            3'b011:         booth_add = m_sx << 1;
            3'b100:         booth_add = -(m_sx << 1);
            3'b101, 3'b110: booth_add = -m_sx;
            default:        booth_add = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_READ_OP;
            end
            S_READ_OP: begin
                op_d    = INBUS[1:0];
                state_d = S_READ_1;
            end
            S_READ_1: begin
                if (op_q == OP_MUL) q_d = INBUS;
                else                a_d = {2'b00, INBUS};
                state_d = S_READ_2;
            end
            S_READ_2: begin
                if (op_q == OP_DIV) q_d = INBUS;
                else                m_d = INBUS;
                state_d = S_READ_3;
            end
            S_READ_3: begin
                if (op_q == OP_DIV) m_d = INBUS;
                state_d = S_OP_1;
            end
            S_OP_1: begin
                unique case (op_q)
                    OP_ADD, OP_SUB: begin
                        a_d     = {2'b00, sum[WIDTH-1:0]};
                        q_d     = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
                        err_d   = ovf;
                        state_d = S_OUT_1;
                    end
                    OP_MUL: begin
                        a_d     = a_q + booth_add;
                        state_d = S_OP_2;
                    end
                    OP_DIV: begin
                        if (cnt_q == '0 && div_err) begin
                            err_d   = 1'b1;
                            state_d = S_OUT_1;
                        end else if (cnt_q == '0) begin
                            // first step folds in the initial left shift
                            a_d     = a_shl - m_zx;
                            q_d     = {q_q[WIDTH-2:0], 1'b0};
                            state_d = S_OP_2;
                        end else begin
                            a_d     = a_q[AW-1] ? a_q + m_zx : a_q - m_zx;
                            state_d = S_OP_2;
                        end
                    end
                endcase
            end
            S_OP_2: begin
                cnt_d = cnt_q + CNT_ONE;
                if (op_q == OP_MUL) begin
                    a_d   = {{2{a_q[AW-1]}}, a_q[AW-1:2]};
                    q_d   = {a_q[1:0], q_q[WIDTH-1:2]};
                    qm1_d = q_q[1];
                    state_d = (cnt_q == MUL_LAST) ? S_OUT_1 : S_OP_1;
                end else if (cnt_q == DIV_LAST) begin
                    state_d = S_DIV_CORR;
                end else begin
                    a_d     = a_shl;
                    q_d     = {q_q[WIDTH-2:1], ~a_q[AW-1], 1'b0};
                    state_d = S_OP_1;
                end
            end
            S_DIV_CORR: begin
                if (a_q[AW-1]) a_d = a_q + m_zx;
                q_d     = {q_q[WIDTH-1:1], ~a_q[AW-1]};
                state_d = S_OUT_1;
            end
            S_OUT_1: begin
                err_d   = err_q;
                state_d = S_OUT_2;
            end
            default: begin
                state_d = S_IDLE;
                op_d    = '0;
                a_d     = '0;
                q_d     = '0;
                qm1_d   = 1'b0;
                m_d     = '0;
                cnt_d   = '0;
            end
        endcase

        outbus_d = '0;
        finish_d = 1'b0;
        busy_d   = (state_d != S_IDLE);
        if (state_d == S_OUT_1) begin
            outbus_d = a_d[WIDTH-1:0];
            finish_d = 1'b1;
        end else if (state_d == S_OUT_2) begin
            outbus_d = q_d;
            finish_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            cnt_q    <= '0;
            outbus_q <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            outbus_q <= outbus_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign OUTBUS = outbus_q;
    assign finish = finish_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_engine.sv
// Directed bench for alu_seq_engine at WIDTH=8 and WIDTH=16.
// Each operation checks latency, both result words, err and return to idle.
module tb_alu_seq_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st8, st16;
    logic [7:0]  in8, out8;
    logic [15:0] in16, out16;
    logic        fin8, busy8, err8;
    logic        fin16, busy16, err16;

    int total = 0;
    int bad   = 0;

    logic [31:0] o_out;
    logic        o_fin, o_busy, o_err;

    alu_seq_engine #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .INBUS(in8),
        .OUTBUS(out8), .finish(fin8), .busy(busy8), .err(err8)
    );

    alu_seq_engine #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .INBUS(in16),
        .OUTBUS(out16), .finish(fin16), .busy(busy16), .err(err16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample(input bit wide);
        if (wide) begin
            o_out = {16'h0, out16};
            o_fin = fin16; o_busy = busy16; o_err = err16;
        end else begin
            o_out = {24'h0, out8};
            o_fin = fin8; o_busy = busy8; o_err = err8;
        end
    endtask

    task automatic drive(input bit wide, input logic [31:0] v);
        if (wide) in16 = v[15:0];
        else      in8  = v[7:0];
    endtask

    task automatic set_start(input bit wide, input logic v);
        if (wide) st16 = v;
        else      st8  = v;
    endtask

    // Called at a negedge with the selected DUT idle; returns at the
    // negedge after R+2 with the DUT expected idle again.
    task automatic run(input string nm, input bit wide, input bit keep,
                       input logic [1:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] s3,
                       input logic [31:0] w1, input logic [31:0] w2,
                       input logic er, input int r);
        int e;
        set_start(wide, 1'b1);
        @(negedge clk);
        sample(wide);
        chk($sformatf("%s.busy", nm), {31'h0, o_busy}, 32'h1);
        set_start(wide, keep);
        drive(wide, {30'h2AAAAAAA, op});
        @(negedge clk); drive(wide, s1);
        @(negedge clk); drive(wide, s2);
        @(negedge clk); drive(wide, s3);
        e = 3;
        do begin
            @(negedge clk);
            e++;
            sample(wide);
        end while (!o_fin && e < 100);
        chk($sformatf("%s.lat", nm), e, r);
        chk($sformatf("%s.w1", nm), o_out, w1);
        chk($sformatf("%s.err1", nm), {31'h0, o_err}, {31'h0, er});
        @(negedge clk);
        sample(wide);
        chk($sformatf("%s.fin2", nm), {31'h0, o_fin}, 32'h1);
        chk($sformatf("%s.w2", nm), o_out, w2);
        chk($sformatf("%s.err2", nm), {31'h0, o_err}, {31'h0, er});
        @(negedge clk);
        sample(wide);
        chk($sformatf("%s.idle", nm),
            {o_fin, o_busy, o_err, o_out[28:0]}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        st8 = 1'b0; st16 = 1'b0;
        in8 = '0;   in16 = '0;
        #1;
        sample(0);
        chk("rst8", {o_fin, o_busy, o_err, o_out[28:0]}, 32'h0);
        sample(1);
        chk("rst16", {o_fin, o_busy, o_err, o_out[28:0]}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("add_ovf", 0, 0, 2'b00, 32'h7F, 32'h01, 32'h55, 32'h80, 32'h00, 1'b1, 5);
        run("add_wrap", 0, 0, 2'b00, 32'hFF, 32'h01, 32'h00, 32'h00, 32'h01, 1'b0, 5);
        run("sub_neg", 0, 0, 2'b01, 32'h05, 32'h07, 32'h00, 32'hFE, 32'h00, 1'b0, 5);
        run("sub_pos", 0, 0, 2'b01, 32'h07, 32'h05, 32'h00, 32'h02, 32'h01, 1'b0, 5);
        run("sub_ovf", 0, 0, 2'b01, 32'h80, 32'h01, 32'h00, 32'h7F, 32'h01, 1'b1, 5);
        run("mul_m3x7", 0, 0, 2'b10, 32'hFD, 32'h07, 32'h00, 32'hFF, 32'hEB, 1'b0, 12);
        run("mul_min", 0, 0, 2'b10, 32'h80, 32'h80, 32'h00, 32'h40, 32'h00, 1'b0, 12);
        run("mul_max", 0, 0, 2'b10, 32'h7F, 32'h7F, 32'h00, 32'h3F, 32'h01, 1'b0, 12);
        run("mul_mix", 0, 0, 2'b10, 32'h7F, 32'h80, 32'h00, 32'hC0, 32'h80, 1'b0, 12);
        run("div_100_7", 0, 0, 2'b11, 32'h00, 32'h64, 32'h07, 32'h02, 32'h0E, 1'b0, 21);
        run("div_top", 0, 0, 2'b11, 32'h06, 32'hFF, 32'h07, 32'h06, 32'hFF, 1'b0, 21);
        run("div_small", 0, 0, 2'b11, 32'h00, 32'h07, 32'hFF, 32'h07, 32'h00, 1'b0, 21);
        run("div_zero", 0, 0, 2'b11, 32'h00, 32'h64, 32'h00, 32'h00, 32'h64, 1'b1, 5);
        run("div_qovf", 0, 0, 2'b11, 32'h09, 32'h00, 32'h07, 32'h09, 32'h00, 1'b1, 5);

        // asynchronous reset in the middle of a multiply
        st8 = 1'b1;
        @(negedge clk); st8 = 1'b0; in8 = 8'h02;
        @(negedge clk); in8 = 8'hFD;
        @(negedge clk); in8 = 8'h07;
        @(negedge clk); in8 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        sample(0);
        chk("midmul.busy", {31'h0, o_busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1 sample(0);
        chk("midmul.rst", {o_fin, o_busy, o_err, o_out[28:0]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        sample(0);
        chk("midmul.stay", {o_fin, o_busy, o_err, o_out[28:0]}, 32'h0);
        run("after_rst", 0, 0, 2'b10, 32'hFD, 32'h07, 32'h00, 32'hFF, 32'hEB, 1'b0, 12);

        // start held high: one operation per return to IDLE
        run("hold_1", 0, 1, 2'b00, 32'h10, 32'h20, 32'h00, 32'h30, 32'h00, 1'b0, 5);
        run("hold_2", 0, 0, 2'b01, 32'h30, 32'h10, 32'h00, 32'h20, 32'h01, 1'b0, 5);

        run("w16_add", 1, 0, 2'b00, 32'h7FFF, 32'h0001, 32'h0, 32'h8000, 32'h0000, 1'b1, 5);
        run("w16_sub", 1, 0, 2'b01, 32'h1234, 32'h5678, 32'h0, 32'hBBBC, 32'h0000, 1'b0, 5);
        run("w16_mul_neg", 1, 0, 2'b10, 32'hFFFF, 32'h1234, 32'h0, 32'hFFFF, 32'hEDCC, 1'b0, 20);
        run("w16_mul_min", 1, 0, 2'b10, 32'h8000, 32'h8000, 32'h0, 32'h4000, 32'h0000, 1'b0, 20);
        run("w16_mul_pos", 1, 0, 2'b10, 32'h0123, 32'h0456, 32'h0, 32'h0004, 32'hEDC2, 1'b0, 20);
        run("w16_div", 1, 0, 2'b11, 32'h0001, 32'h0000, 32'h0003, 32'h0001, 32'h5555, 1'b0, 37);
        run("w16_div_ovf", 1, 0, 2'b11, 32'h1234, 32'h5678, 32'h1234, 32'h1234, 32'h5678, 1'b1, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_engine.md
# alu_seq_engine

Parametrised sequential integer ALU with the same word-serial INBUS/OUTBUS protocol as the current 8-bit ALU control unit, generalised to any even operand width. It supports signed add/subtract with overflow detection, signed radix-4 Booth multiply, and unsigned non-restoring 2W/W divide with divide-by-zero and quotient-overflow detection. A status flag and a busy output are added. It sits between the host byte/word bus and the datapath primitives (adder, ff, counter, mux2_1).

## Interface
- WIDTH, 8, operand and bus width in bits; must be even, 4..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- INBUS  in  WIDTH  opcode and operand words, one per cycle.
- OUTBUS  out  WIDTH  result words; 0 when finish=0.
- finish  out  1  high during both result cycles.
- busy  out  1  high in every state except IDLE.
- err  out  1  error flag; valid while finish=1, otherwise 0.

## Operation
- Opcode is INBUS[1:0]; upper bits are ignored.
  - ADD=00, SUB=01, MUL=10, DIV=11.
- Operand slots (always three; slot 3 is ignored unless DIV):
  - ADD/SUB: slot1 = A, slot2 = B.
  - MUL: slot1 = multiplier Q, slot2 = multiplicand M.
  - DIV: slot1 = dividend high, slot2 = dividend low, slot3 = divisor M.
- FSM sequence: IDLE -> READ_OP -> READ_1 -> READ_2 -> READ_3 -> OP_1.
  - From OP_1: [OP_2 -> OP_1 ...] -> [DIV_CORR] -> OUT_1 -> OUT_2 -> IDLE.
  - Unused encodings go to IDLE.
- All datapath registers clear on entry to IDLE.
- The accumulator is WIDTH+2 bits internally; this is needed for ±2M.
- ADD/SUB:
  - Single OP_1 cycle.
  - word1 = (A ± B) mod 2^WIDTH.
  - word2 = {0…, carry-out of A + B or A + ~B + 1}.
  - err = signed two's-complement overflow.
- MUL:
  - WIDTH/2 iterations of OP_1 (Booth add of 0, ±M or ±2M, selected by {Q[1],Q[0],Q_-1}) followed by OP_2 (arithmetic shift right by 2 of {A,Q,Q_-1}, counter increment).
  - word1 = product high, word2 = product low (signed, 2·WIDTH bits).
  - err = 0.
- DIV:
  - In OP_1 with count = 0, if M = 0 or dividend_high ≥ M (unsigned): err = 1, next state OUT_1, registers untouched.
    - word1 = dividend high, word2 = dividend low.
  - Otherwise: WIDTH non-restoring iterations of OP_1 (subtract M if the partial remainder is ≥ 0, else add M) followed by OP_2 (shift {A,Q} left; new Q LSB = ~sign).
    - OP_2 of the last iteration does not shift.
  - Then DIV_CORR: add M if the remainder is negative, and set the final quotient bit.
  - word1 = remainder, word2 = quotient, err = 0.
- start is ignored while busy = 1; it is never queued.

## Timing
- Reset (rst_n low, at any time, including mid-operation):
  - Immediately: state = IDLE; OUTBUS = 0, finish = 0, busy = 0, err = 0; all registers cleared.
  - Operation resumes only after a new start following deassertion.
- Edges: start sampled high at edge E0.
  - Opcode captured at E1.
  - Slot1 at E2, slot2 at E3, slot3 at E4.
  - busy rises after E0.
- First OP_1 cycle is E4–E5. Result phase begins at edge R:
  - ADD/SUB and DIV error: R = E5.
  - MUL: R = E(4+WIDTH).
  - DIV normal: R = E(5+2·WIDTH).
- Cycle R–R+1: OUT_1, OUTBUS = word1, finish = 1.
- Cycle R+1–R+2: OUT_2, OUTBUS = word2, finish = 1.
- At R+2 the FSM is in IDLE with busy = 0; start may be sampled at R+2.
- err holds its value across both OUT cycles.

## Test plan
(WIDTH = 8 unless stated.)
- ADD 0x7F + 0x01 -> word1 0x80, word2 0x00, err = 1; finish high exactly 2 cycles starting after E5.
- SUB 0x05 − 0x07 -> 0xFE / 0x00, err = 0; SUB 0x07 − 0x05 -> 0x02 / 0x01; SUB 0x80 − 0x01 -> 0x7F, err = 1.
- MUL Q = 0xFD (−3), M = 0x07 -> 0xFF / 0xEB, finish after E12; MUL 0x80 × 0x80 -> 0x40 / 0x00.
- DIV {0x00,0x64} / 0x07 -> remainder 0x02, quotient 0x0E, err = 0, finish after E21.
- DIV {0x00,0x64} / 0x00 -> err = 1, 0x00 / 0x64, finish after E5; DIV {0x09,0x00} / 0x07 -> err = 1.
- Control and regression:
  - rst_n pulsed low mid-MUL -> all outputs 0 immediately, IDLE.
  - start held high through a whole operation -> exactly one operation per return to IDLE.
  - Repeat the random add/sub/mul/div checks at WIDTH = 16 against a reference model.
